pe_acc_drain: RTL and testbench
===============================

# pe_acc_drain

Per-column accumulation controller and output drain placed directly below a column of processing elements. It sequences the PE accumulator enables (`clr_o`/`en_o`) over a programmed reduction length, then captures the final column sum from the bottom PE. It requantizes that sum (rounding right shift, then saturation) and buffers results in a small FIFO behind a valid/ready output port.

## Interface
Parameters:
- OWIDTH, 24, width of the accumulated partial sum arriving from the PE column
- QWIDTH, 8, width of the requantized signed output
- DEPTH, 4, result FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run one reduction; honoured only in IDLE
- k_len  in  16  number of accumulate cycles; sampled on an accepted start
- shamt  in  5  right-shift amount for requantization, 0..OWIDTH-1; sampled on an accepted start
- ofm_sum  in  OWIDTH signed  registered sum from the bottom PE of the column
- clr_o  out  1  accumulator clear to the column
- en_o  out  1  accumulator enable to the column
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse when a result is written into the FIFO
- out_data  out  QWIDTH signed  head of the FIFO
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready

## Operation
- FSM states: IDLE, CLEAR, ACCUM, CAPTURE.
- IDLE: start=1 latches k_len and shamt, then goes to CLEAR. start in any other state is ignored.
- CLEAR: clr_o=1 for exactly one cycle.
  - k_len≠0 → ACCUM, with the cycle counter loaded to k_len.
  - k_len=0 → CAPTURE directly; the captured sum is then the cleared value 0.
- ACCUM: en_o=1 every cycle and the counter decrements. The cycle in which the counter is 1 is the last ACCUM cycle; the next state is CAPTURE.
- CAPTURE: samples ofm_sum, requantizes it and pushes the result into the FIFO; done=1 on the push cycle, then the FSM returns to IDLE.
  - If the FIFO is full and no pop occurs in the same cycle, the FSM stays in CAPTURE with en_o=0 and clr_o=0. ofm_sum is held by the PEs because en_o is low.
- Requantization, with s = latched shamt:
  - r = (ofm_sum + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in OWIDTH+1 bits so the rounding add cannot overflow. This is round-half-up.
  - Saturate r to [−2^(QWIDTH−1), 2^(QWIDTH−1)−1].
- FIFO:
  - Push and pop in the same cycle are both performed, including when the FIFO is full or empty-then-push.
  - A pop with out_valid=0 is ignored.
  - out_data is the registered head entry and is stable while out_valid && !out_ready.
- clr_o and en_o are never high in the same cycle.

## Timing
- Reset values: clr_o=0, en_o=0, busy=0, done=0, out_valid=0, out_data=0. The FSM is in IDLE, the counter is 0 and the FIFO is empty.
- rst in any state, including mid-ACCUM or a stalled CAPTURE, returns to these values on the next edge. FIFO contents are discarded.
- Cycle sequence with start accepted at cycle 0 (FIFO not full):
  - cycle 1: CLEAR, clr_o=1.
  - cycles 2..k_len+1: ACCUM, en_o=1.
  - cycle k_len+2: CAPTURE, done=1.
  - cycle k_len+3: out_valid=1 and busy=0.
- With k_len=0, CAPTURE is at cycle 2.
- Back-to-back: start is accepted on the first IDLE cycle after CAPTURE, so one reduction occupies k_len+3 cycles.
- busy is combinational from state. done is combinational from (state==CAPTURE && push).

## Test plan
- Basic: k_len=4, shamt=0, PE model sums 3 per en_o cycle.
  - clr_o at cycle 1, en_o at cycles 2–5, done at cycle 6.
  - out_data=12, out_valid at cycle 7.
- Rounding and saturation: shamt=4.
  - ofm_sum=40 → 3 (40+8=48, >>>4=3).
  - ofm_sum=−24 → −1.
  - ofm_sum=5000 → 127.
  - ofm_sum=−5000 → −128.
- k_len=0: clr_o for 1 cycle, no en_o, CAPTURE at cycle 2, out_data=0.
- FIFO full, DEPTH=4, out_ready=0:
  - Five reductions: the fifth stalls in CAPTURE with busy=1 and en_o=0.
  - Raise out_ready for one cycle: the first result pops, the fifth is pushed the same cycle, and done pulses.
  - Results then drain in order.
- Ignored start and reset mid-run:
  - start pulsed during ACCUM has no effect.
  - rst asserted at the third ACCUM cycle: the next cycle has en_o=0, busy=0, out_valid=0, and the FIFO is empty.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/pe_acc_drain.sv
// pe_acc_drain: accumulation sequencer and output drain below one PE column.
// Runs one reduction for each accepted start:
//   CLEAR  - one cycle with clr_o high.
//   ACCUM  - k_len cycles with en_o high.
//   CAPTURE- samples ofm_sum, requantizes it, and pushes the result into the FIFO.
// Requantization is a round-half-up arithmetic right shift followed by
// saturation to QWIDTH signed bits.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, k_len, shamt run request plus its parameters (latched in IDLE)
//   ofm_sum             column sum from the bottom PE
//   clr_o, en_o         accumulator controls driven to the column
//   busy, done          FSM not idle; pulse on each result push
//   out_data/valid/ready result stream (head of the FIFO)
module pe_acc_drain #(
  parameter int OWIDTH = 24,
  parameter int QWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              k_len,
  input  logic [4:0]               shamt,
  input  logic signed [OWIDTH-1:0] ofm_sum,
  output logic                     clr_o,
  output logic                     en_o,
  output logic                     busy,
  output logic                     done,
  output logic signed [QWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, CAPTURE} state_e;

  state_e            state_q, state_d;
  logic [15:0]       k_q, k_d, cnt_q, cnt_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [QWIDTH-1:0] mem_q [DEPTH];
  logic [QWIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       fill_q, fill_d;

  logic push, pop, full;
  logic signed [OWIDTH:0] ext, rnd, rsum, rsh;
  logic [OWIDTH-QWIDTH+1:0] hi;
  logic [QWIDTH-1:0] qval;

  // The rounding add uses one extra bit of width, so it cannot overflow.
  always_comb begin
    ext  = {ofm_sum[OWIDTH-1], ofm_sum};
    rnd  = (shamt_q == 5'd0) ? '0 : ((OWIDTH+1)'(1) << (shamt_q - 5'd1));
    rsum = ext + rnd;
    rsh  = rsum >>> shamt_q;
    // The value fits in QWIDTH bits when every bit from QWIDTH-1 upward
    // is a copy of the sign bit.
    hi   = rsh[OWIDTH:QWIDTH-1];
    if ((&hi) || !(|hi)) qval = rsh[QWIDTH-1:0];
    else if (rsh[OWIDTH]) qval = {1'b1, {(QWIDTH-1){1'b0}}};
    else                  qval = {1'b0, {(QWIDTH-1){1'b1}}};
  end

  assign out_valid = (fill_q != '0);
  assign out_data  = $signed(mem_q[rd_q]);
  assign full      = (fill_q == (AW+1)'(DEPTH));
  assign pop       = out_valid && out_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot that this push uses.
  assign push      = (state_q == CAPTURE) && (!full || pop);

  assign busy  = (state_q != IDLE);
  assign clr_o = (state_q == CLEAR);
  assign en_o  = (state_q == ACCUM);
  assign done  = push;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        k_d     = k_len;
        shamt_d = shamt;
        state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = k_q;
        // With k_len = 0 the capture sees the freshly cleared value (zero).
        state_d = (k_q == 16'd0) ? CAPTURE : ACCUM;
      end
      ACCUM: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = CAPTURE;
      end
      CAPTURE: if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    if (push) begin
      mem_d[wr_q] = qval;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_pe_acc_drain.sv
module tb_pe_acc_drain;
  localparam int OW = 24;
  localparam int QW = 8;

  logic clk = 1'b0;
  logic rst, start, clr_o, en_o, busy, done, out_valid, out_ready;
  logic [15:0] k_len;
  logic [4:0] shamt;
  logic signed [OW-1:0] ofm_sum;
  logic signed [QW-1:0] out_data;

  logic signed [OW-1:0] pe_inc;
  logic signed [OW-1:0] pe_sum = 24'sh000123;

  int ncmp = 0;
  int nerr = 0;
  int exp_q[$];
  bit ab;

  pe_acc_drain #(.OWIDTH(OW), .QWIDTH(QW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .shamt(shamt),
    .ofm_sum(ofm_sum), .clr_o(clr_o), .en_o(en_o), .busy(busy), .done(done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural PE column: it clears on clr_o and adds pe_inc on each en_o.
  always_ff @(posedge clk) begin
    if (clr_o)     pe_sum <= '0;
    else if (en_o) pe_sum <= pe_sum + pe_inc;
  end
  assign ofm_sum = pe_sum;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result: round half up, arithmetic shift (floor), then clamp.
  function automatic int model_q(input longint v, input int s);
    longint r;
    r = (s > 0) ? ((v + (longint'(1) << (s - 1))) >>> s) : v;
    if (r > (2**(QW-1)) - 1) r = (2**(QW-1)) - 1;
    if (r < -(2**(QW-1)))    r = -(2**(QW-1));
    return int'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs from the start cycle up to the CAPTURE cycle. It returns early
  // if a reset is applied at ACCUM step rst_at. At ACCUM step poke_at it
  // pulses a start that must be ignored.
  task automatic start_run(input int k, input int inc, input int s,
                           input int poke_at, input int rst_at, output bit aborted);
    aborted = 0;
    pe_inc  = OW'(inc);
    start   = 1'b1;
    k_len   = 16'(k);
    shamt   = 5'(s);
    tick();
    start = 1'b0;
    chk("clear_clr", int'(clr_o), 1);
    chk("clear_en", int'(en_o), 0);
    for (int i = 1; i <= k; i++) begin
      tick();
      start = 1'b0;
      chk("accum_en", int'(en_o), 1);
      chk("accum_clr", int'(clr_o), 0);
      if (i == poke_at) begin
        start = 1'b1;
        k_len = 16'd1;
        shamt = 5'd0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_en", int'(en_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        aborted = 1;
        return;
      end
    end
    tick();
    start = 1'b0;
    chk("capture_en", int'(en_o), 0);
    chk("capture_busy", int'(busy), 1);
    exp_q.push_back(model_q(longint'(k) * longint'(inc), s));
  endtask

  task automatic finish_run();
    chk("done", int'(done), 1);
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("out_valid", int'(out_valid), 1);
  endtask

  task automatic pop_check();
    chk("pop_valid", int'(out_valid), 1);
    chk("out_data", int'(out_data), exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; shamt = '0; out_ready = 1'b0; pe_inc = '0;
    tick(); tick();
    chk("rst_clr", int'(clr_o), 0);
    chk("rst_en0", int'(en_o), 0);
    chk("rst_busy0", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid0", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    rst = 1'b0;
    tick();

    // Basic reduction: 4 x 3 = 12
    start_run(4, 3, 0, -1, -1, ab);
    finish_run();
    pop_check();
    chk("empty_after_pop", int'(out_valid), 0);

    // Rounding and saturation; leaves four results queued (FIFO full)
    start_run(1, 40, 4, -1, -1, ab);    finish_run();
    start_run(1, -24, 4, -1, -1, ab);   finish_run();
    start_run(1, 5000, 4, -1, -1, ab);  finish_run();
    start_run(1, -5000, 4, -1, -1, ab); finish_run();
    chk("round_40", exp_q[0], 3);
    chk("round_m24", exp_q[1], -1);
    chk("sat_pos", exp_q[2], 127);
    chk("sat_neg", exp_q[3], -128);

    // Fifth reduction stalls in CAPTURE until one result is popped
    start_run(2, 7, 0, -1, -1, ab);
    chk("stall_done", int'(done), 0);
    tick(); tick();
    chk("stall_done2", int'(done), 0);
    chk("stall_busy", int'(busy), 1);
    chk("stall_en", int'(en_o), 0);
    chk("stall_clr", int'(clr_o), 0);
    chk("stall_head", int'(out_data), exp_q[0]);
    out_ready = 1'b1;
    #1;
    chk("unstall_done", int'(done), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("unstall_busy", int'(busy), 0);
    while (exp_q.size() > 0) pop_check();
    chk("drained", int'(out_valid), 0);

    // k_len = 0: CAPTURE directly after CLEAR, result 0
    start_run(0, 5, 0, -1, -1, ab);
    finish_run();
    pop_check();

    // A start pulse during ACCUM is ignored (the run keeps k=3, s=1)
    start_run(3, 9, 1, 1, -1, ab);
    finish_run();
    chk("ignored_start_busy", int'(busy), 0);
    pop_check();

    // Reset at the third ACCUM cycle discards a queued result
    start_run(1, 100, 0, -1, -1, ab);
    finish_run();
    start_run(6, 2, 0, -1, 3, ab);
    chk("rst_aborted", int'(ab), 1);
    exp_q.delete();
    tick();
    chk("rst_still_empty", int'(out_valid), 0);

    // Randomized reductions after the reset
    for (int n = 0; n < 16; n++) begin
      int k, inc, s;
      k   = int'($urandom_range(0, 10));
      inc = int'($urandom_range(0, 2**19)) - 2**18;
      s   = int'($urandom_range(0, 23));
      start_run(k, inc, s, -1, -1, ab);
      finish_run();
      pop_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
